// File: rtl/maze_generator.sv
// Binary-tree maze generator.
//
// Carves a perfect maze (spanning tree) into a 64x64 path grid, one cell per
// clock. Row 0 of cells always carves east and the last column always carves
// north; every other cell picks north or east from the LSB of a 16-bit Galois
// LFSR.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   start        request a new maze (sampled only when idle)
//   seed         LFSR seed, latched on an accepted start (0 selects 16'hACE1)
//   cells_w/h    maze size in cells (1..31, 0 treated as 1), latched on start
//   path_data    path grid, bit x+64*y, 1 = open path
//   maze_width   path-grid width  = 2*cells_w+1
//   maze_height  path-grid height = 2*cells_h+1
//   busy         high while clearing or carving
//   done         one-cycle pulse when the maze is complete
module maze_generator (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [15:0]    seed,
  input  logic [4:0]     cells_w,
  input  logic [4:0]     cells_h,
  output logic [4095:0]  path_data,
  output logic [6:0]     maze_width,
  output logic [6:0]     maze_height,
  output logic           busy,
  output logic           done
);

  localparam logic [15:0] LfsrDefault = 16'hACE1;
  localparam logic [15:0] LfsrTaps    = 16'hB400;

  typedef enum logic [1:0] {StIdle, StClear, StCarve, StDone} state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q;
  logic [4:0]    w_q, h_q;
  logic [4:0]    cx_q, cy_q;
  logic [6:0]    width_q, height_q;
  logic [4095:0] path_q, path_d;

  logic          accept;
  logic          last_x, last_y;
  logic [5:0]    px, py;
  logic          carve_east, carve_north;
  logic [11:0]   cell_idx, east_idx, north_idx;

  assign accept = (state_q == StIdle) && start;
  assign last_x = (cx_q == w_q - 5'd1);
  assign last_y = (cy_q == h_q - 5'd1);

  // Path-grid coordinates of the cell centre; always odd.
  assign px = {cx_q, 1'b1};
  assign py = {cy_q, 1'b1};

  always_comb begin
    carve_east  = 1'b0;
    carve_north = 1'b0;
    if (cy_q == 5'd0) begin
      carve_east = !last_x;
    end else if (last_x) begin
      carve_north = 1'b1;
    end else begin
      carve_north = lfsr_q[0];
      carve_east  = !lfsr_q[0];
    end
  end

  // px, py < 64, so x+64*y is a plain concatenation; neighbours stay in range
  // because px+1 <= 62 and py-1 >= 0.
  assign cell_idx  = {py, px};
  assign east_idx  = {py, px + 6'd1};
  assign north_idx = {py - 6'd1, px};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StClear;
      StClear: state_d = StCarve;
      StCarve: if (last_x && last_y) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StClear, StCarve: busy = 1'b1;
      StDone:           done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Path grid
  // ---------------------------------------------------------------------------
  always_comb begin
    path_d = path_q;
    if (state_q == StClear) begin
      path_d = '0;
    end else if (state_q == StCarve) begin
      path_d[cell_idx] = 1'b1;
      if (carve_east)  path_d[east_idx]  = 1'b1;
      if (carve_north) path_d[north_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      path_q <= '0;
    end else begin
      path_q <= path_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: LFSR, latched sizes, cell counters, grid dimensions
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q   <= LfsrDefault;
      w_q      <= 5'd1;
      h_q      <= 5'd1;
      cx_q     <= 5'd0;
      cy_q     <= 5'd0;
      width_q  <= 7'd0;
      height_q <= 7'd0;
    end else begin
      if (accept) begin
        lfsr_q <= (seed == 16'd0) ? LfsrDefault : seed;
        w_q    <= (cells_w == 5'd0) ? 5'd1 : cells_w;
        h_q    <= (cells_h == 5'd0) ? 5'd1 : cells_h;
      end
      if (state_q == StClear) begin
        cx_q     <= 5'd0;
        cy_q     <= 5'd0;
        width_q  <= {1'b0, w_q, 1'b1};
        height_q <= {1'b0, h_q, 1'b1};
      end
      if (state_q == StCarve) begin
        // Advance after this cycle's lfsr_q[0] has been consumed.
        lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LfsrTaps : 16'd0);
        if (last_x) begin
          cx_q <= 5'd0;
          cy_q <= cy_q + 5'd1;
        end else begin
          cx_q <= cx_q + 5'd1;
        end
      end
    end
  end

  assign path_data   = path_q;
  assign maze_width  = width_q;
  assign maze_height = height_q;

endmodule

// File: tb/tb_maze_generator.sv
module tb_maze_generator;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   seed;
  logic [4:0]    cells_w, cells_h;
  logic [4095:0] path_data;
  logic [6:0]    maze_width, maze_height;
  logic          busy, done;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  maze_generator dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .seed        (seed),
    .cells_w     (cells_w),
    .cells_h     (cells_h),
    .path_data   (path_data),
    .maze_width  (maze_width),
    .maze_height (maze_height),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference: build the whole maze from the carving rules in one go.
  // ---------------------------------------------------------------------------
  function automatic logic [4095:0] gen_maze(input logic [15:0] sd, input int w, input int h);
    logic [4095:0] g;
    logic [15:0]   r;
    int            x, y;
    g = '0;
    r = (sd == 16'd0) ? 16'hACE1 : sd;
    for (int cy = 0; cy < h; cy++) begin
      for (int cx = 0; cx < w; cx++) begin
        x = 2 * cx + 1;
        y = 2 * cy + 1;
        g[x + 64 * y] = 1'b1;
        if (cy == 0) begin
          if (cx != w - 1) g[x + 1 + 64 * y] = 1'b1;
        end else if (cx == w - 1) begin
          g[x + 64 * (y - 1)] = 1'b1;
        end else if (r[0]) begin
          g[x + 64 * (y - 1)] = 1'b1;
        end else begin
          g[x + 1 + 64 * y] = 1'b1;
        end
        r = (r >> 1) ^ (r[0] ? 16'hB400 : 16'h0000);
      end
    end
    return g;
  endfunction

  // Model timeline: m_since counts cycles after the accepted start.
  bit            m_active = 1'b0;
  int            m_since  = 0;
  int            m_cells  = 1;
  logic [4095:0] m_path   = '0;
  logic [4095:0] m_next   = '0;
  int            m_w = 0, m_h = 0, m_nw = 0, m_nh = 0;

  always @(posedge clk) begin
    int w, h;
    if (reset) begin
      m_active <= 1'b0;
      m_since  <= 0;
      m_path   <= '0;
      m_w      <= 0;
      m_h      <= 0;
    end else if (!m_active) begin
      if (start) begin
        w = (cells_w == 0) ? 1 : int'(cells_w);
        h = (cells_h == 0) ? 1 : int'(cells_h);
        m_active <= 1'b1;
        m_since  <= 1;
        m_cells  <= w * h;
        m_nw     <= 2 * w + 1;
        m_nh     <= 2 * h + 1;
        m_next   <= gen_maze(seed, w, h);
      end
    end else begin
      m_since <= m_since + 1;
      if (m_since == 1) begin
        m_w <= m_nw;
        m_h <= m_nh;
      end
      if (m_since + 1 == 2 + m_cells) m_path <= m_next;
      if (m_since == 2 + m_cells) m_active <= 1'b0;
    end
  end

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_path(input string name, input logic [4095:0] act,
                            input logic [4095:0] exp);
    int first;
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      first = -1;
      for (int i = 0; i < 4096; i++) if (first < 0 && act[i] !== exp[i]) first = i;
      $display("FAIL %s: got popcount %0d expected popcount %0d, first differing bit %0d (t=%0t)",
               name, $countones(act), $countones(exp), first, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check_int("busy", int'(busy), int'(m_active && m_since >= 1 && m_since <= 1 + m_cells));
      check_int("done", int'(done), int'(m_active && m_since == 2 + m_cells));
      check_int("maze_width", int'(maze_width), m_w);
      check_int("maze_height", int'(maze_height), m_h);
      if (!m_active || m_since == 1 || m_since >= 2 + m_cells)
        check_path("path_data", path_data, m_path);
    end
  end

  // Start a maze and wait for done; lat = cycles from start to done.
  task automatic run_maze(input logic [4:0] w, input logic [4:0] h, input logic [15:0] sd,
                          output int lat, output logic [7:0] busy_mask);
    @(negedge clk);
    seed = sd; cells_w = w; cells_h = h; start = 1'b1;
    lat = -1;
    busy_mask = '0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k < 8) busy_mask[k] = busy;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check_int("done_timeout", lat, 0);
  endtask

  logic [4095:0] exp_p, p1, p2, mask;
  logic [7:0]    bm;
  int            lat;

  initial begin
    reset = 1'b1; start = 1'b0; seed = '0; cells_w = '0; cells_h = '0;
    repeat (2) @(negedge clk);
    check_path("reset_path", path_data, '0);
    check_int("reset_width", int'(maze_width), 0);
    check_int("reset_height", int'(maze_height), 0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // 1x1: single cell.
    run_maze(5'd1, 5'd1, 16'h0001, lat, bm);
    check_int("lat_1x1", lat, 3);
    check_int("busy_1x1", int'(bm), 8'b0000_0110);
    exp_p = '0; exp_p[65] = 1'b1;
    check_path("path_1x1", path_data, exp_p);
    check_int("width_1x1", int'(maze_width), 3);
    check_int("height_1x1", int'(maze_height), 3);

    // 3x1: one corridor along y=1.
    run_maze(5'd3, 5'd1, 16'h7777, lat, bm);
    check_int("lat_3x1", lat, 5);
    exp_p = '0;
    for (int i = 65; i <= 69; i++) exp_p[i] = 1'b1;
    check_path("path_3x1", path_data, exp_p);
    check_int("width_3x1", int'(maze_width), 7);

    // 1x3: one corridor along x=1.
    run_maze(5'd1, 5'd3, 16'h0F0F, lat, bm);
    check_int("lat_1x3", lat, 5);
    exp_p = '0;
    exp_p[65] = 1'b1; exp_p[129] = 1'b1; exp_p[193] = 1'b1;
    exp_p[257] = 1'b1; exp_p[321] = 1'b1;
    check_path("path_1x3", path_data, exp_p);
    check_int("height_1x3", int'(maze_height), 7);

    // Width 0 is treated as 1.
    run_maze(5'd0, 5'd2, 16'h0042, lat, bm);
    check_int("lat_0x2", lat, 4);
    exp_p = '0; exp_p[65] = 1'b1; exp_p[129] = 1'b1; exp_p[193] = 1'b1;
    check_path("path_0x2", path_data, exp_p);
    check_int("width_0x2", int'(maze_width), 3);

    // 8x8 with a fixed seed.
    run_maze(5'd8, 5'd8, 16'h1234, lat, bm);
    check_int("lat_8x8", lat, 66);
    check_int("popcount_8x8", $countones(path_data), 127);
    p1 = path_data;
    mask = '0;
    for (int i = 0; i < 64; i++) begin
      mask[i] = 1'b1; mask[i + 64 * 16] = 1'b1;
      mask[64 * i] = 1'b1; mask[16 + 64 * i] = 1'b1;
    end
    check_path("border_8x8", path_data & mask, '0);
    repeat (3) @(negedge clk);
    check_path("hold_idle", path_data, p1);
    run_maze(5'd8, 5'd8, 16'h1234, lat, bm);
    check_path("rerun_8x8", path_data, p1);

    run_maze(5'd8, 5'd8, 16'h0000, lat, bm);
    p2 = path_data;
    run_maze(5'd8, 5'd8, 16'hACE1, lat, bm);
    check_path("seed0_eq_ace1", path_data, p2);

    // Start pulse mid-carve must be ignored.
    @(negedge clk);
    seed = 16'h1234; cells_w = 5'd8; cells_h = 5'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    seed = 16'h5555; cells_w = 5'd2; cells_h = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 12; k <= 300; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    check_int("lat_ignore_start", lat, 66);
    check_path("path_ignore_start", path_data, p1);

    // Reset in the middle of carving.
    @(negedge clk);
    seed = 16'h2222; cells_w = 5'd10; cells_h = 5'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_path("midreset_path", path_data, '0);
    check_int("midreset_busy", int'(busy), 0);
    check_int("midreset_width", int'(maze_width), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_int("midreset_idle_busy", int'(busy), 0);
    run_maze(5'd5, 5'd4, 16'hBEEF, lat, bm);
    check_int("lat_after_reset", lat, 22);
    check_int("popcount_after_reset", $countones(path_data), 39);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
